// File: rtl/sprite_mover.sv
// sprite_mover: bounces a sprite origin around the visible area, one update every fdiv+1 frames.
// Ports: clk/rst_n (async active-low), hc/vc raster counters, en motion enable,
// step pixels per update, fdiv frame divider; posx/posy sprite origin, busy while
// moving, hit_x/hit_y one-cycle bounce pulses.
module sprite_mover #(
  parameter logic [10:0] HRES = 11'd800,
  parameter logic [10:0] VRES = 11'd600,
  parameter logic [10:0] TAM  = 11'd64,
  parameter logic [10:0] X0   = 11'd0,
  parameter logic [10:0] Y0   = 11'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hc,
  input  logic [10:0] vc,
  input  logic        en,
  input  logic [3:0]  step,
  input  logic [3:0]  fdiv,
  output logic [10:0] posx,
  output logic [10:0] posy,
  output logic        busy,
  output logic        hit_x,
  output logic        hit_y
);
  typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y} state_t;
  localparam logic [11:0] XMAX = {1'b0, HRES} - {1'b0, TAM};
  localparam logic [11:0] YMAX = {1'b0, VRES} - {1'b0, TAM};
  state_t      state_q, state_d;
  logic        cmp, cmp_q, tick, fire;
  logic [3:0]  fcnt_q, fcnt_d, step_q;
  logic [10:0] posx_q, posx_d, posy_q, posy_d;
  logic        dx_q, dy_q, hit_x_q, hit_y_q, xhit, yhit;
  logic [11:0] xs, ys;
  assign cmp  = hc == 11'd0 && vc == VRES;
  // rising edge of the compare gives one tick per frame even when hc stalls at 0
  assign tick = cmp && !cmp_q && state_q == IDLE;
  assign fire = tick && fcnt_q == fdiv;
  always_comb begin
    fcnt_d  = tick ? (fire ? 4'd0 : fcnt_q + 4'd1) : fcnt_q;
    state_d = state_q == IDLE ? (fire && en ? MOVE_X : IDLE) : state_q == MOVE_X ? MOVE_Y : IDLE;
    xs      = {1'b0, posx_q} + {8'd0, step};
    ys      = {1'b0, posy_q} + {8'd0, step_q};
    // a zero step never moves or bounces, regardless of position
    xhit    = step != 4'd0 && (dx_q ? xs >= XMAX : {1'b0, posx_q} <= {8'd0, step});
    yhit    = step_q != 4'd0 && (dy_q ? ys >= YMAX : {1'b0, posy_q} <= {8'd0, step_q});
    posx_d  = dx_q ? (xhit ? XMAX[10:0] : xs[10:0]) : (xhit ? 11'd0 : posx_q - {7'd0, step});
    posy_d  = dy_q ? (yhit ? YMAX[10:0] : ys[10:0]) : (yhit ? 11'd0 : posy_q - {7'd0, step_q});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmp_q   <= 1'b0;
      fcnt_q  <= 4'd0;
      step_q  <= 4'd0;
      posx_q  <= X0;
      posy_q  <= Y0;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      hit_x_q <= 1'b0;
      hit_y_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmp_q   <= cmp;
      fcnt_q  <= fcnt_d;
      hit_x_q <= state_q == MOVE_X && xhit;
      hit_y_q <= state_q == MOVE_Y && yhit;
      if (state_q == MOVE_X) begin
        step_q <= step;
        posx_q <= posx_d;
        dx_q   <= dx_q ^ xhit;
      end
      if (state_q == MOVE_Y) begin
        posy_q <= posy_d;
        dy_q   <= dy_q ^ yhit;
      end
    end
  end
  assign posx  = posx_q;
  assign posy  = posy_q;
  assign busy  = state_q != IDLE;
  assign hit_x = hit_x_q;
  assign hit_y = hit_y_q;
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: randomized and directed checks of sprite_mover against a frame-level model.
module tb_sprite_mover;
  localparam int XM = 800 - 64;
  localparam int YM = 600 - 64;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hc = 11'd5;
  logic [10:0] vc = 11'd3;
  logic        en = 1'b0;
  logic [3:0]  step = 4'd0;
  logic [3:0]  fdiv = 4'd0;
  logic [10:0] posx, posy;
  logic        busy, hit_x, hit_y;
  int n_chk = 0;
  int n_fail = 0;
  int m_x, m_y, m_fc;
  bit m_dx, m_dy;

  sprite_mover dut (.clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .en(en), .step(step),
    .fdiv(fdiv), .posx(posx), .posy(posy), .busy(busy), .hit_x(hit_x), .hit_y(hit_y));

  always #5 clk = ~clk;

  // one bounce-axis update expressed directly from the motion rules
  function automatic void axis(inout int p, inout bit d, output bit h, input int s, input int mx);
    h = 1'b0;
    if (s == 0) return;
    if (d) begin
      if (p + s >= mx) begin p = mx; d = 1'b0; h = 1'b1; end else p = p + s;
    end else begin
      if (p <= s) begin p = 0; d = 1'b1; h = 1'b1; end else p = p - s;
    end
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1'b1; m_dy = 1'b1; m_fc = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; hc = 11'd5; vc = 11'd3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // one frame: tick, then observe the two move cycles and the pulse trailing edges
  task automatic frame(input bit stall);
    bit fire, mv, hx, hy;
    int ox, oy;
    ox = m_x; oy = m_y;
    fire = (m_fc == int'(fdiv));
    m_fc = fire ? 0 : (m_fc + 1) % 16;
    mv = fire && en;
    hx = 1'b0; hy = 1'b0;
    if (mv) begin
      axis(m_x, m_dx, hx, int'(step), XM);
      axis(m_y, m_dy, hy, int'(step), YM);
    end
    @(negedge clk); hc = 11'd0; vc = 11'd600;
    @(negedge clk);
    n_chk++; if (busy !== mv || posx !== 11'(ox)) begin n_fail++;
      $display("FAIL tick_cycle busy=%b posx=%0d want busy=%b posx=%0d", busy, posx, mv, ox); end
    if (!stall) begin hc = 11'd5; vc = 11'd3; end
    @(negedge clk);
    n_chk++; if (busy !== mv || posx !== 11'(m_x) || hit_x !== hx || posy !== 11'(oy)) begin n_fail++;
      $display("FAIL movex_cycle busy=%b posx=%0d hit_x=%b posy=%0d want %b %0d %b %0d",
        busy, posx, hit_x, posy, mv, m_x, hx, oy); end
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || posy !== 11'(m_y) || hit_y !== hy || hit_x !== 1'b0) begin n_fail++;
      $display("FAIL movey_cycle busy=%b posy=%0d hit_y=%b hit_x=%b want 0 %0d %b 0",
        busy, posy, hit_y, hit_x, m_y, hy); end
    @(negedge clk);
    n_chk++; if (hit_y !== 1'b0 || busy !== 1'b0 || posx !== 11'(m_x)) begin n_fail++;
      $display("FAIL settle hit_y=%b busy=%b posx=%0d want 0 0 %0d", hit_y, busy, posx, m_x); end
    hc = 11'd5; vc = 11'd3;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (posx !== 11'd0 || posy !== 11'd0 || busy !== 1'b0 || hit_x !== 1'b0 || hit_y !== 1'b0) begin
      n_fail++; $display("FAIL reset posx=%0d posy=%0d busy=%b hx=%b hy=%b want all 0", posx, posy, busy, hit_x, hit_y); end
  endtask

  task automatic test_basic();
    do_reset();
    en = 1'b1; step = 4'd4; fdiv = 4'd0;
    repeat (3) frame(1'b0);
    n_chk++; if (posx !== 11'd12 || posy !== 11'd12) begin n_fail++;
      $display("FAIL basic posx=%0d posy=%0d want 12 12", posx, posy); end
  endtask

  task automatic test_bounce();
    do_reset();
    en = 1'b1; step = 4'd12; fdiv = 4'd0;
    repeat (61) frame(1'b0);
    n_chk++; if (posx !== 11'd732) begin n_fail++; $display("FAIL bounce_pre posx=%0d want 732", posx); end
    step = 4'd8;
    frame(1'b0);
    n_chk++; if (posx !== 11'd736 || m_dx) begin n_fail++; $display("FAIL bounce_edge posx=%0d want 736", posx); end
    frame(1'b0);
    n_chk++; if (posx !== 11'd728) begin n_fail++; $display("FAIL bounce_back posx=%0d want 728", posx); end
  endtask

  task automatic test_fdiv();
    do_reset();
    en = 1'b1; step = 4'd1; fdiv = 4'd3;
    repeat (8) frame(1'b1);
    n_chk++; if (posx !== 11'd2 || posy !== 11'd2) begin n_fail++;
      $display("FAIL fdiv posx=%0d posy=%0d want 2 2", posx, posy); end
  endtask

  task automatic test_hold();
    int sx, sy;
    sx = m_x; sy = m_y;
    en = 1'b0; step = 4'd7; fdiv = 4'd1;
    repeat (5) frame(1'b0);
    en = 1'b1; step = 4'd0;
    repeat (5) frame(1'b0);
    n_chk++; if (posx !== 11'(sx) || posy !== 11'(sy)) begin n_fail++;
      $display("FAIL hold posx=%0d posy=%0d want %0d %0d", posx, posy, sx, sy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; step = 4'd10; fdiv = 4'd0;
    repeat (10) frame(1'b0);
    n_chk++; if (posx !== 11'd100) begin n_fail++; $display("FAIL mid_pre posx=%0d want 100", posx); end
    @(negedge clk); hc = 11'd0; vc = 11'd600;
    @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy busy=%b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (posx !== 11'd0 || busy !== 1'b0 || hit_x !== 1'b0) begin n_fail++;
      $display("FAIL mid_abort posx=%0d busy=%b hit_x=%b want 0 0 0", posx, busy, hit_x); end
    @(negedge clk); hc = 11'd5; vc = 11'd3;
    n_chk++; if (hit_x !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL mid_hold hit_x=%b busy=%b want 0 0", hit_x, busy); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    frame(1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 9) != 0);
      step = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) fdiv = 4'($urandom_range(0, 3));
      frame(1'($urandom_range(0, 1)));
    end
    n_chk++; if (posx !== 11'(m_x) || posy !== 11'(m_y)) begin n_fail++;
      $display("FAIL random_end posx=%0d posy=%0d want %0d %0d", posx, posy, m_x, m_y); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_fdiv();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
